diag_stim_seq: RTL and testbench

Synchronous stimulus sequencer that drives the single-bit (or narrow) data input of a diagnostic DUT such as `foo`. It sits directly upstream of the DUT instance inside `main` and replaces a hard-tied constant like `1'b0` with a repeatable pseudo-random sequence. A sticky `done` flag tells the enclosing testbench when it may call `$finish`. The block gives coverage diagnostics real toggle, FSM and line activity while keeping runs deterministic.

---
 rtl/diag_stim_defs.sv | 19 +
 rtl/diag_stim_seq_if.sv | 20 ++
 rtl/diag_lfsr8.sv | 39 +++
 rtl/diag_stim_seq.sv | 112 +++++++++++
 tb/tb_diag_stim_seq.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/diag_stim_defs.sv
// rtl/diag_stim_defs.sv - shared state encodings and LFSR constants for the stimulus sequencer
package diag_stim_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'h01;

    // Galois right-shift step; a nonzero state never maps to zero.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/diag_stim_seq_if.sv
// rtl/diag_stim_seq_if.sv - stimulus word handshake between sequencer and diagnostic DUT
interface diag_stim_seq_if #(
    parameter int WIDTH = 1
) ();
    logic [WIDTH-1:0] stim_out;
    logic             stim_valid;
    logic             stim_ready;

    modport master (
        output stim_out,
        output stim_valid,
        input  stim_ready
    );

    modport slave (
        input  stim_out,
        input  stim_valid,
        output stim_ready
    );
endinterface

// File: rtl/diag_lfsr8.sv
// rtl/diag_lfsr8.sv - 8-bit Galois LFSR with seed load and zero-seed substitution
module diag_lfsr8
    import diag_stim_defs::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       advance,
    input  logic [7:0] seed,
    output logic [7:0] value
);

    logic [7:0] seed_eff;
    logic [7:0] value_q;
    logic [7:0] value_d;

    // A zero state would lock the register, so substitute the default seed.
    assign seed_eff = (seed == 8'h00) ? DEFAULT_SEED : seed;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = seed_eff;
        end else if (advance) begin
            value_d = lfsr_next(value_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= seed_eff;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/diag_stim_seq.sv
// rtl/diag_stim_seq.sv - repeatable pseudo-random stimulus sequencer with hold spacing and sticky done
module diag_stim_seq
    import diag_stim_defs::*;
#(
    parameter int         WIDTH       = 1,
    parameter int         NUM_STEPS   = 8,
    parameter int         HOLD_CYCLES = 2,
    parameter logic [7:0] SEED        = DEFAULT_SEED
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             pause,
    diag_stim_seq_if.master                  stim,
    output logic [$clog2(NUM_STEPS+1)-1:0]   step_count,
    output logic                             done
);

    localparam int            SW        = $clog2(NUM_STEPS + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);
    localparam bit            HAS_HOLD  = (HOLD_CYCLES > 0);
    localparam logic [3:0]    HOLD_LOAD = HAS_HOLD ? 4'(HOLD_CYCLES - 1) : 4'd0;

    state_e        state_q, state_d;
    logic [3:0]    hold_q, hold_d;
    logic [SW-1:0] step_q, step_d;
    logic          done_q, done_d;
    logic          xfer;
    logic          lfsr_load;
    logic [7:0]    lfsr_value;
    logic          unused_lfsr;

    // Pause gates valid directly so it always wins over stim_ready.
    assign stim.stim_valid = (state_q == ST_RUN) && !pause;
    assign xfer            = stim.stim_valid && stim.stim_ready;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        step_d    = step_q;
        done_d    = done_q;
        lfsr_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    lfsr_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    step_d = step_q + 1'b1;
                    if (step_q == LAST_STEP) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (HAS_HOLD) begin
                        state_d = ST_HOLD;
                        hold_d  = HOLD_LOAD;
                    end
                end
            end
            ST_HOLD: begin
                if (!pause) begin
                    if (hold_q == 4'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    step_d    = '0;
                    done_d    = 1'b0;
                    lfsr_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= 4'd0;
            step_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    diag_lfsr8 u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .load    (lfsr_load),
        .advance (xfer),
        .seed    (SEED),
        .value   (lfsr_value)
    );

    assign stim.stim_out = lfsr_value[WIDTH-1:0];
    // Upper LFSR bits feed the sequence but are not presented when WIDTH < 8.
    assign unused_lfsr   = ^lfsr_value;
    assign step_count    = step_q;
    assign done          = done_q;

endmodule

// File: tb/tb_diag_stim_seq.sv
// tb/tb_diag_stim_seq.sv - directed self-checking bench for diag_stim_seq
module tb_diag_stim_seq;

    logic       clock = 1'b0;
    logic       reset;
    logic       start0, pause0, start1, pause1, start2, pause2;
    logic [3:0] step0, step1;
    logic [0:0] step2;
    logic       done0, done1, done2;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] seq [0:9];

    always #5 clock = ~clock;

    diag_stim_seq_if #(.WIDTH(8)) if0 ();
    diag_stim_seq_if #(.WIDTH(8)) if1 ();
    diag_stim_seq_if #(.WIDTH(1)) if2 ();

    diag_stim_seq #(.WIDTH(8), .NUM_STEPS(8), .HOLD_CYCLES(0), .SEED(8'h01)) u0 (
        .clock(clock), .reset(reset), .start(start0), .pause(pause0),
        .stim(if0), .step_count(step0), .done(done0)
    );

    diag_stim_seq #(.WIDTH(8), .NUM_STEPS(8), .HOLD_CYCLES(2), .SEED(8'h01)) u1 (
        .clock(clock), .reset(reset), .start(start1), .pause(pause1),
        .stim(if1), .step_count(step1), .done(done1)
    );

    diag_stim_seq #(.WIDTH(1), .NUM_STEPS(1), .HOLD_CYCLES(0), .SEED(8'h00)) u2 (
        .clock(clock), .reset(reset), .start(start2), .pause(pause2),
        .stim(if2), .step_count(step2), .done(done2)
    );

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        seq = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1, 8'hC8, 8'h64, 8'h32};
        reset = 1'b1;
        start0 = 1'b0; pause0 = 1'b0; start1 = 1'b0; pause1 = 1'b0; start2 = 1'b0; pause2 = 1'b0;
        if0.stim_ready = 1'b0;
        if1.stim_ready = 1'b0;
        if2.stim_ready = 1'b1;
        tick();
        tick();
        check("rst_out0",   32'(if0.stim_out),   32'h01);
        check("rst_valid0", 32'(if0.stim_valid), 32'd0);
        check("rst_step0",  32'(step0),          32'd0);
        check("rst_done0",  32'(done0),          32'd0);
        check("rst_out2",   32'(if2.stim_out),   32'd1);
        check("rst_valid1", 32'(if1.stim_valid), 32'd0);
        reset = 1'b0;

        // basic run, no hold, ready tied high
        if0.stim_ready = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("t1_valid", 32'(if0.stim_valid), 32'd1);
        check("t1_first", 32'(if0.stim_out),   32'h01);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("t1_out%0d", k),  32'(if0.stim_out), 32'(seq[k]));
            check($sformatf("t1_step%0d", k), 32'(step0),        32'(k));
            check($sformatf("t1_done%0d", k), 32'(done0),        32'(k == 8));
        end
        check("t1_valid_done", 32'(if0.stim_valid), 32'd0);
        tick();
        check("t1_done_sticky", 32'(done0),        32'd1);
        check("t1_out_hold",    32'(if0.stim_out), 32'h64);

        // restart from DONE with backpressure
        if0.stim_ready = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("t4_done_clr",  32'(done0),          32'd0);
        check("t4_step_clr",  32'(step0),          32'd0);
        check("t4_seed",      32'(if0.stim_out),   32'h01);
        check("t4_valid",     32'(if0.stim_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_bp_out",  32'(if0.stim_out), 32'h01);
            check("t3_bp_step", 32'(step0),        32'd0);
        end
        if0.stim_ready = 1'b1;
        tick();
        check("t3_rel_out",  32'(if0.stim_out), 32'hB8);
        check("t3_rel_step", 32'(step0),        32'd1);
        pause0 = 1'b1;
        #1;
        check("t3_pause_valid", 32'(if0.stim_valid), 32'd0);
        tick();
        tick();
        check("t3_pause_out",  32'(if0.stim_out), 32'hB8);
        check("t3_pause_step", 32'(step0),        32'd1);
        pause0 = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("t4_run_start_out",  32'(if0.stim_out), 32'h5C);
        check("t4_run_start_step", 32'(step0),        32'd2);
        tick();
        check("t5_pre_out",  32'(if0.stim_out), 32'h2E);
        check("t5_pre_step", 32'(step0),        32'd3);

        // reset collides with start and ready
        reset = 1'b1;
        start0 = 1'b1;
        tick();
        check("t5_out",   32'(if0.stim_out),   32'h01);
        check("t5_valid", 32'(if0.stim_valid), 32'd0);
        check("t5_step",  32'(step0),          32'd0);
        check("t5_done",  32'(done0),          32'd0);
        reset = 1'b0;
        start0 = 1'b0;
        tick();
        check("t5_idle_valid", 32'(if0.stim_valid), 32'd0);
        check("t5_idle_step",  32'(step0),          32'd0);

        // hold spacing: valid pattern 1,0,0 repeating for eight words
        if1.stim_ready = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 22; i++) begin
            check($sformatf("t2_valid%0d", i), 32'(if1.stim_valid), 32'(i % 3 == 0));
            if (i % 3 == 0) begin
                check($sformatf("t2_out%0d", i),  32'(if1.stim_out), 32'(seq[i / 3]));
                check($sformatf("t2_step%0d", i), 32'(step1),        32'(i / 3));
            end
            tick();
        end
        check("t2_done",  32'(done1),          32'd1);
        check("t2_step8", 32'(step1),          32'd8);
        check("t2_last",  32'(if1.stim_out),   32'h64);
        check("t2_valid", 32'(if1.stim_valid), 32'd0);

        // pause in HOLD freezes the hold counter
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("t3h_valid0", 32'(if1.stim_valid), 32'd1);
        check("t3h_out0",   32'(if1.stim_out),   32'h01);
        tick();
        check("t3h_hold_valid", 32'(if1.stim_valid), 32'd0);
        check("t3h_step1",      32'(step1),          32'd1);
        pause1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3h_frz_valid", 32'(if1.stim_valid), 32'd0);
            check("t3h_frz_step",  32'(step1),          32'd1);
        end
        pause1 = 1'b0;
        #1;
        check("t3h_resume0", 32'(if1.stim_valid), 32'd0);
        tick();
        check("t3h_resume1", 32'(if1.stim_valid), 32'd0);
        tick();
        check("t3h_resume2", 32'(if1.stim_valid), 32'd1);
        check("t3h_out1",    32'(if1.stim_out),   32'hB8);

        // edge parameters: zero seed, single step, single-bit width
        pause2 = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("t6_paused_valid", 32'(if2.stim_valid), 32'd0);
        check("t6_paused_step",  32'(step2),          32'd0);
        tick();
        check("t6_paused_valid2", 32'(if2.stim_valid), 32'd0);
        pause2 = 1'b0;
        #1;
        check("t6_valid", 32'(if2.stim_valid), 32'd1);
        check("t6_out",   32'(if2.stim_out),   32'd1);
        tick();
        check("t6_done",       32'(done2),          32'd1);
        check("t6_step",       32'(step2),          32'd1);
        check("t6_out_next",   32'(if2.stim_out),   32'd0);
        check("t6_valid_done", 32'(if2.stim_valid), 32'd0);
        tick();
        check("t6_sticky", 32'(done2), 32'd1);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("t6_re_done", 32'(done2),        32'd0);
        check("t6_re_step", 32'(step2),        32'd0);
        check("t6_re_out",  32'(if2.stim_out), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
